// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier controller: digit width,
// controller state encoding and the digit-count helper.
package mult_pkg;

  localparam int DIGIT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of 8-bit digits in an operand of the given width
  function automatic int digits(input int width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/mult_8bit.sv
// Combinational 8x8 unsigned multiplier tile, reused over every digit pair
// by the sequencing controller.
module mult_8bit (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] Result
);

  assign Result = A * B;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier: one mult_8bit tile is walked
// over all digit pairs (j inner, i outer) and the shifted partial products are
// summed into a 2*WIDTH accumulator. Valid/ready handshakes on both sides.
// Optional build macro: MULT_SEQ_PIPE_EN registers the tile output and shift
// amount ahead of the accumulator and adds a one-cycle DRAIN state.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Result,
  output logic               busy
);

  localparam int N  = digits(WIDTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(PW);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [CW-1:0]        i_q, j_q;
  logic [PW-1:0]        acc;
  logic [DIGIT_W-1:0]   dig_a, dig_b;
  logic [2*DIGIT_W-1:0] pp;
  logic [SW-1:0]        sh;
  logic [2*DIGIT_W-1:0] add_pp;
  logic [SW-1:0]        add_sh;
  logic                 add_en;
  logic [PW-1:0]        term;
  logic                 accept;
  logic                 last_step;

  assign accept    = in_valid && in_ready;
  assign last_step = (state == RUN) && (i_q == LAST) && (j_q == LAST);

  // Select the current digit pair and its weight in the product
  always_comb begin
    dig_a = DIGIT_W'(a_q >> (int'(i_q) * DIGIT_W));
    dig_b = DIGIT_W'(b_q >> (int'(j_q) * DIGIT_W));
    sh    = SW'((int'(i_q) + int'(j_q)) * DIGIT_W);
  end

  mult_8bit u_tile (
    .A      (dig_a),
    .B      (dig_b),
    .Result (pp)
  );

`ifdef MULT_SEQ_PIPE_EN
  logic [2*DIGIT_W-1:0] pp_p1;
  logic [SW-1:0]        sh_p1;
  logic                 vld_p1;

  // ---- stage p1: tile output and its shift registered ahead of the adder
  always_ff @(posedge clk) begin
    pp_p1 <= pp;
    sh_p1 <= sh;
  end

  // Marks p1 as holding a partial product that still has to be summed
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= (state == RUN);
  end

  assign add_pp = pp_p1;
  assign add_sh = sh_p1;
  assign add_en = vld_p1;
`else
  assign add_pp = pp;
  assign add_sh = sh;
  assign add_en = (state == RUN);
`endif

  assign term = PW'(add_pp) << add_sh;

  // Capture operands on accept; they may change freely afterwards
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= A;
      b_q <= B;
    end
  end

  // Accumulator: cleared on accept, sums shifted partial products modulo 2^PW
  always_ff @(posedge clk) begin
    if (rst)         acc <= '0;
    else if (accept) acc <= '0;
    else if (add_en) acc <= acc + term;
  end

  // Digit counters: j is the inner loop, i the outer loop
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      i_q <= '0;
      j_q <= '0;
    end else if (state == RUN) begin
      if (j_q == LAST) begin
        j_q <= '0;
        i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
      end else begin
        j_q <= j_q + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = RUN;
`ifdef MULT_SEQ_PIPE_EN
      RUN:   if (last_step) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
`else
      RUN:   if (last_step) state_nxt = DONE;
`endif
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is a registered view of IDLE, dropped on the accept edge so a
  // second operand pair can never be taken while RUN starts
  always_ff @(posedge clk) begin
    if (rst)         in_ready <= 1'b1;
    else if (accept) in_ready <= 1'b0;
    else             in_ready <= (state == IDLE);
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign Result    = acc;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed WIDTH=32 sequence plus
// random streams on WIDTH=8 and WIDTH=64 instances, scoreboard per instance.
module tb_mult_seq_ctrl;

`ifdef MULT_SEQ_PIPE_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif
  localparam int N32 = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=32 instance
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [31:0] c_A, c_B;
  logic [63:0] c_Result;
  // WIDTH=8 instance
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [7:0]  s_A, s_B;
  logic [15:0] s_Result;
  // WIDTH=64 instance
  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic [63:0]  w_A, w_B;
  logic [127:0] w_Result;

  mult_seq_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .A(c_A), .B(c_B), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .Result(c_Result), .busy(c_busy));

  mult_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .A(s_A), .B(s_B), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .Result(s_Result), .busy(s_busy));

  mult_seq_ctrl #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .A(w_A), .B(w_B), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .Result(w_Result), .busy(w_busy));

  logic [63:0]  q32[$];
  logic [15:0]  q8[$];
  logic [127:0] q64[$];
  int           hs32[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitors: compare every completed handshake against the queue
  always @(negedge clk) begin
    if (c_out_valid && c_out_ready) begin
      hs32.push_back(cyc);
      check("w32_sb_nonempty", 128'(q32.size() > 0), 128'(1));
      if (q32.size() > 0) check("w32_result", 128'(c_Result), 128'(q32.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (s_out_valid && s_out_ready) begin
      check("w8_sb_nonempty", 128'(q8.size() > 0), 128'(1));
      if (q8.size() > 0) check("w8_result", 128'(s_Result), 128'(q8.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (w_out_valid && w_out_ready) begin
      check("w64_sb_nonempty", 128'(q64.size() > 0), 128'(1));
      if (q64.size() > 0) check("w64_result", w_Result, q64.pop_front());
    end
  end

  task automatic wait_ready32();
    int t = 0;
    while (!c_in_ready && t < 100) begin
      tick(1);
      t++;
    end
    if (t >= 100) check("w32_ready_timeout", 128'(c_in_ready), 128'(1));
  endtask

  // Present an operand pair, wait for acceptance, record the expected product
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input bit keep);
    c_A = a;
    c_B = b;
    c_in_valid = 1'b1;
    wait_ready32();
    tick(1);
    q32.push_back(64'(a) * 64'(b));
    if (!keep) c_in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen (accept edge = 0)
  task automatic wait_out32(output int lat);
    lat = 1;
    while (!c_out_valid && lat < 300) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    s_A = a;
    s_B = b;
    s_in_valid = 1'b1;
    while (!s_in_ready && t < 100) begin
      tick(1);
      t++;
    end
    if (t >= 100) check("w8_ready_timeout", 128'(s_in_ready), 128'(1));
    tick(1);
    q8.push_back(16'(a) * 16'(b));
  endtask

  task automatic issue64(input logic [63:0] a, input logic [63:0] b);
    int t = 0;
    w_A = a;
    w_B = b;
    w_in_valid = 1'b1;
    while (!w_in_ready && t < 200) begin
      tick(1);
      t++;
    end
    if (t >= 200) check("w64_ready_timeout", 128'(w_in_ready), 128'(1));
    tick(1);
    q64.push_back(128'(a) * 128'(b));
  endtask

  initial begin
    int lat;
    int t;
    logic [63:0] hold_exp;

    rst = 1'b1;
    c_in_valid = 0; c_out_ready = 1; c_A = '0; c_B = '0;
    s_in_valid = 0; s_out_ready = 1; s_A = '0; s_B = '0;
    w_in_valid = 0; w_out_ready = 1; w_A = '0; w_B = '0;
    tick(3);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 128'(c_in_ready), 128'(1));
    check("rst_out_valid", 128'(c_out_valid), 128'(0));
    check("rst_busy", 128'(c_busy), 128'(0));
    check("rst_result", 128'(c_Result), 128'(0));

    // Small product, latency and single-cycle out_valid
    issue32(32'h3, 32'h5, 1'b0);
    check("run_busy", 128'(c_busy), 128'(1));
    check("run_in_ready", 128'(c_in_ready), 128'(0));
    wait_out32(lat);
    check("lat_3x5", 128'(lat), 128'(N32 * N32 + 1 + PX));
    check("done_busy", 128'(c_busy), 128'(0));
    tick(1);
    check("out_valid_one_cycle", 128'(c_out_valid), 128'(0));

    // All-ones operands: full carry propagation
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_out32(lat);
    check("lat_ones", 128'(lat), 128'(N32 * N32 + 1 + PX));
    check("ones_value", 128'(c_Result), 128'(64'hFFFF_FFFE_0000_0001));
    tick(1);

    // Backpressure: result holds, new operands ignored
    c_out_ready = 1'b0;
    issue32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    hold_exp = 64'h0B00_EA4E_242D_2080;
    wait_out32(lat);
    for (int k = 0; k < 10; k++) begin
      c_in_valid = 1'b1;
      c_A = $urandom;
      c_B = $urandom;
      check("hold_out_valid", 128'(c_out_valid), 128'(1));
      check("hold_result", 128'(c_Result), 128'(hold_exp));
      check("hold_in_ready", 128'(c_in_ready), 128'(0));
      tick(1);
    end
    c_in_valid = 1'b0;
    c_out_ready = 1'b1;
    tick(1);
    check("hold_released", 128'(c_out_valid), 128'(0));
    issue32(32'h6, 32'h7, 1'b0);
    wait_out32(lat);
    check("lat_after_hold", 128'(lat), 128'(N32 * N32 + 1 + PX));
    tick(1);

    // Reset during RUN aborts without output
    c_A = 32'h9;
    c_B = 32'h9;
    c_in_valid = 1'b1;
    wait_ready32();
    tick(1);
    c_in_valid = 1'b0;
    tick(7);
    check("abort_busy_before", 128'(c_busy), 128'(1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_out_valid", 128'(c_out_valid), 128'(0));
    check("abort_busy", 128'(c_busy), 128'(0));
    check("abort_in_ready", 128'(c_in_ready), 128'(1));
    check("abort_result", 128'(c_Result), 128'(0));
    issue32(32'h2, 32'h7, 1'b0);
    wait_out32(lat);
    check("lat_after_abort", 128'(lat), 128'(N32 * N32 + 1 + PX));
    check("after_abort_value", 128'(c_Result), 128'(14));
    tick(1);

    // Back-to-back stream with in_valid held high
    hs32.delete();
    issue32(32'hDEAD_BEEF, 32'h0000_0010, 1'b1);
    issue32(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    issue32(32'h8000_0001, 32'h7FFF_FFFF, 1'b1);
    c_in_valid = 1'b0;
    t = 0;
    while (q32.size() > 0 && t < 200) begin
      tick(1);
      t++;
    end
    check("b2b_drained", 128'(q32.size()), 128'(0));
    check("b2b_count", 128'(hs32.size()), 128'(3));
    if (hs32.size() == 3) begin
      for (int k = 1; k < 3; k++)
        check("b2b_spacing", 128'(hs32[k] - hs32[k-1]), 128'(N32 * N32 + 3 + PX));
    end
    tick(2);

    // Random streams on the 8- and 64-bit instances
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          if (k == 0)      issue8(8'h00, 8'hFF);
          else if (k == 1) issue8(8'hFF, 8'hFF);
          else             issue8(8'($urandom), 8'($urandom));
        end
        s_in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 400; k++) begin
          if (k == 0)      issue64(64'h0, {$urandom, $urandom});
          else if (k == 1) issue64({64{1'b1}}, {64{1'b1}});
          else             issue64({$urandom, $urandom}, {$urandom, $urandom});
        end
        w_in_valid = 1'b0;
      end
    join
    t = 0;
    while ((q8.size() > 0 || q64.size() > 0) && t < 500) begin
      tick(1);
      t++;
    end
    check("w8_drained", 128'(q8.size()), 128'(0));
    check("w64_drained", 128'(q64.size()), 128'(0));
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
